uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the existing UART transmitter link.
- Oversamples the serial line on a single fast clock (`rx_clk`) and locates each start bit.
- Samples every bit at mid-bit; reassembles the data LSB first; checks optional parity and the stop bit.
- Presents each received word with a one-cycle valid strobe and error flags.

Parameters:
- Data_length, 8, number of data bits per frame (1..16).
- parity_en, 0, 1 = a parity bit follows the data bits; 0 = no parity bit.
- clk_per_bit, 20, rx_clk cycles per serial bit (even, >= 4); must match the transmitter's clk_per_bit.

Ports:
- rx_clk  input  1  receive clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- serialdata_in  input  1  serial line, idle high; asynchronous to rx_clk.
- parity_type  input  1  0 = expected parity bit is ^data (even); 1 = ~(^data) (odd). Sampled at the parity mid-bit sample.
- dataout  output  Data_length  last received word, LSB = first data bit on line.
- rx_valid  output  1  one-cycle pulse: dataout/parity_err/frame_err updated this cycle.
- parity_err  output  1  parity mismatch on last frame (always 0 if parity_en=0).
- frame_err  output  1  stop bit sampled low on last frame.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): dataout=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0, state=IDLE, counters=0.
- Reset also presets both synchronizer flops to 1, so no false start occurs on release.
- Input sync: 2-flop synchronizer on serialdata_in; all decisions use the synced bit `rxs`. Edge detect compares rxs with its previous value.
- Baud counter: 0..clk_per_bit-1; cleared on every state entry.
- Bit counter: width clog2(Data_length+1); counts data bits received.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Wait for a falling edge of rxs (1->0); then go to START.
  - A line held low without a new 1->0 edge never triggers.
- START:
  - At baud count clk_per_bit/2-1, sample rxs.
  - If 0: go to DATA, clear baud counter. This point is the mid-bit reference.
  - If 1: false start (glitch); return to IDLE. No rx_valid, flags unchanged.
- DATA:
  - At baud count clk_per_bit-1, sample rxs into shift register bit [bitcount], LSB first; bitcount+1.
  - After Data_length samples, clear bitcount and go to PARITY if parity_en=1, else STOP.
- PARITY:
  - At baud count clk_per_bit-1, sample rxs.
  - Internal perr = rxs XOR (parity_type ? ~(^shift) : ^shift).
  - Go to STOP.
- STOP:
  - At baud count clk_per_bit-1, sample rxs; ferr = ~rxs.
  - Next clock:
    - dataout <= shift; parity_err <= perr (0 if parity_en=0); frame_err <= ferr; rx_valid = 1 for exactly one cycle.
    - State returns to IDLE in the same cycle.
  - The remaining half stop bit lets back-to-back frames with a 1-bit stop be received with no idle gap.
- Error frames:
  - Frames with a parity or frame error still deliver dataout and rx_valid.
  - Flags hold their values until the next rx_valid.
- Frame error with line stuck low (break): FSM returns to IDLE and waits for the line to rise, then fall, before the next start.
- rx_valid pulses are never back-to-back; the minimum spacing is one full frame.
- Latency: rx_valid rises 2 (sync) + clk_per_bit/2 + (Data_length+parity_en+1)*clk_per_bit + 1 cycles after the start-bit falling edge on serialdata_in, with ±1 cycle edge-alignment uncertainty.
- Mid-frame reset: frame is aborted and all outputs return to reset values immediately. After release, the FSM is in IDLE and needs a fresh falling edge.
- parity_type changes: changes outside the parity sample cycle have no effect on the current frame.

Test Plan:
- parity_en=0, clk_per_bit=20. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one rx_valid pulse; dataout=0xA5; parity_err=0; frame_err=0; rx_busy low after the pulse.
- parity_en=1, parity_type=0. Send 0x07 with parity bit 1 -> dataout=0x07, parity_err=0. Repeat with parity bit 0 -> rx_valid pulses, parity_err=1. Set parity_type=1 and send 0x07 with parity bit 0 -> parity_err=0.
- Send 0x3C with stop bit 0, then hold the line low for 3 bit times -> dataout=0x3C, frame_err=1, exactly one rx_valid. Raise the line, then send 0x11 normally -> dataout=0x11, frame_err=0.
- Low glitch on an idle line for 5 rx_clk cycles (< clk_per_bit/2) -> no rx_valid, rx_busy returns to 0, flags unchanged.
- Back-to-back 0x00 then 0xFF, with no idle between the stop bit and the next start bit -> two rx_valid pulses exactly one frame apart; dataout=0x00, then 0xFF.
- Assert rst low during the 4th data bit of 0x5A -> all outputs 0 immediately. Release, then send 0xC3 -> dataout=0xC3, no errors.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start detect, mid-bit sampling, LSB-first
// reassembly, optional parity and stop-bit checking with a one-cycle strobe.
module uart_receiver #(
    parameter int Data_length = 8,
    parameter int parity_en   = 0,
    parameter int clk_per_bit = 20
) (
    input  logic                   rx_clk,
    input  logic                   rst,
    input  logic                   serialdata_in,
    input  logic                   parity_type,
    output logic [Data_length-1:0] dataout,
    output logic                   rx_valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   rx_busy
);

    localparam int BW = $clog2(clk_per_bit);
    localparam int CW = $clog2(Data_length + 1);
    localparam logic [BW-1:0] HALF = BW'(clk_per_bit / 2 - 1);
    localparam logic [BW-1:0] LAST = BW'(clk_per_bit - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(Data_length - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state, state_n;

    logic                   sync1, rxs, rxs_d;
    logic [BW-1:0]          baud;
    logic [CW-1:0]          bit_cnt;
    logic [Data_length-1:0] shift;
    logic [Data_length:0]   shift_ext;
    logic                   perr;
    logic                   fall;
    logic                   parity_exp;
    logic                   baud_clr, bit_inc, bit_clr;
    logic                   shift_en, par_en, stop_en;

    assign fall       = rxs_d & ~rxs;
    assign shift_ext  = {rxs, shift};
    assign parity_exp = parity_type ? ~(^shift) : ^shift;
    assign rx_busy    = (state != IDLE);

    always_comb begin
        state_n  = state;
        baud_clr = 1'b0;
        bit_inc  = 1'b0;
        bit_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        unique case (state)
            IDLE: begin
                baud_clr = 1'b1;
                if (fall) state_n = START;
            end
            START: begin
                if (baud == HALF) begin
                    baud_clr = 1'b1;
                    state_n  = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud == LAST) begin
                    baud_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_clr = 1'b1;
                        state_n = (parity_en != 0) ? PARITY : STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud == LAST) begin
                    baud_clr = 1'b1;
                    par_en   = 1'b1;
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (baud == LAST) begin
                    baud_clr = 1'b1;
                    stop_en  = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                baud_clr = 1'b1;
                state_n  = IDLE;
            end
        endcase
    end

    // Synchronizer presets high so release never looks like a start edge.
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= serialdata_in;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
        end else begin
            state <= state_n;
            if (baud_clr) baud <= '0;
            else          baud <= baud + BW'(1);
            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + CW'(1);
            if (shift_en) shift <= shift_ext[Data_length:1];
            if (par_en)   perr  <= rxs ^ parity_exp;
        end
    end

    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            dataout    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= stop_en;
            if (stop_en) begin
                dataout    <= shift;
                parity_err <= (parity_en != 0) ? perr : 1'b0;
                frame_err  <= ~rxs;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one instance without parity,
// one with parity, each driven on its own serial line.
module tb_uart_receiver;

    localparam int CPB = 20;
    localparam int DL  = 8;

    logic          clk;
    logic          rst;
    logic          sd0, sd1;
    logic          pt0, pt1;
    logic [DL-1:0] d0, d1;
    logic          v0, v1, pe0, pe1, fe0, fe1, b0, b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    int vcyc0 = 0;
    int pcyc0 = 0;
    int base;
    int gap;

    uart_receiver #(.Data_length(DL), .parity_en(0), .clk_per_bit(CPB)) u0 (
        .rx_clk(clk), .rst(rst), .serialdata_in(sd0), .parity_type(pt0),
        .dataout(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0),
        .rx_busy(b0)
    );

    uart_receiver #(.Data_length(DL), .parity_en(1), .clk_per_bit(CPB)) u1 (
        .rx_clk(clk), .rst(rst), .serialdata_in(sd1), .parity_type(pt1),
        .dataout(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1),
        .rx_busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) begin
            cnt0  <= cnt0 + 1;
            pcyc0 <= vcyc0;
            vcyc0 <= cyc;
        end
        if (v1) cnt1 <= cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit0(input logic b);
        sd0 = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic bit1(input logic b);
        sd1 = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic frame0(input logic [DL-1:0] d, input logic stp);
        bit0(1'b0);
        for (int i = 0; i < DL; i++) bit0(d[i]);
        bit0(stp);
    endtask

    task automatic frame1(input logic [DL-1:0] d, input logic par);
        bit1(1'b0);
        for (int i = 0; i < DL; i++) bit1(d[i]);
        bit1(par);
        bit1(1'b1);
    endtask

    task automatic settle();
        sd0 = 1'b1;
        sd1 = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        sd0 = 1'b1;
        sd1 = 1'b1;
        pt0 = 1'b0;
        pt1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dataout", 32'(d0), 32'h0);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_busy", 32'(b0), 32'h0);
        check("rst_flags", 32'({pe0, fe0, pe1, fe1}), 32'h0);
        rst = 1'b1;
        settle();

        base = cnt0;
        frame0(8'hA5, 1'b1);
        check("a5_pulses", 32'(cnt0 - base), 32'd1);
        check("a5_data", 32'(d0), 32'hA5);
        check("a5_flags", 32'({pe0, fe0}), 32'h0);
        check("a5_busy", 32'(b0), 32'h0);
        settle();

        frame1(8'h07, 1'b1);
        check("p_even_ok_data", 32'(d1), 32'h07);
        check("p_even_ok_perr", 32'(pe1), 32'h0);
        settle();
        base = cnt1;
        frame1(8'h07, 1'b0);
        check("p_even_bad_pulse", 32'(cnt1 - base), 32'd1);
        check("p_even_bad_perr", 32'(pe1), 32'h1);
        settle();
        pt1 = 1'b1;
        frame1(8'h07, 1'b0);
        check("p_odd_ok_perr", 32'(pe1), 32'h0);
        check("p_odd_ok_ferr", 32'(fe1), 32'h0);
        settle();

        base = cnt0;
        frame0(8'h3C, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("brk_pulses", 32'(cnt0 - base), 32'd1);
        check("brk_data", 32'(d0), 32'h3C);
        check("brk_ferr", 32'(fe0), 32'h1);
        check("brk_busy", 32'(b0), 32'h0);
        settle();
        frame0(8'h11, 1'b1);
        check("after_brk_data", 32'(d0), 32'h11);
        check("after_brk_ferr", 32'(fe0), 32'h0);
        settle();

        base = cnt0;
        sd0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sd0 = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
        check("glitch_pulses", 32'(cnt0 - base), 32'd0);
        check("glitch_busy", 32'(b0), 32'h0);
        check("glitch_flags", 32'({d0, pe0, fe0}), 32'({8'h11, 2'b00}));
        settle();

        base = cnt0;
        frame0(8'h00, 1'b1);
        check("b2b_first_data", 32'(d0), 32'h00);
        frame0(8'hFF, 1'b1);
        check("b2b_pulses", 32'(cnt0 - base), 32'd2);
        check("b2b_second_data", 32'(d0), 32'hFF);
        gap = vcyc0 - pcyc0;
        check("b2b_spacing", 32'(gap), 32'(10 * CPB));
        settle();

        bit0(1'b0);
        bit0(1'b0);
        bit0(1'b1);
        bit0(1'b0);
        sd0 = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        check("mid_busy", 32'(b0), 32'h1);
        rst = 1'b0;
        #1;
        check("mrst_data", 32'(d0), 32'h0);
        check("mrst_outs", 32'({v0, pe0, fe0, b0}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        settle();
        base = cnt0;
        frame0(8'hC3, 1'b1);
        check("post_rst_pulse", 32'(cnt0 - base), 32'd1);
        check("post_rst_data", 32'(d0), 32'hC3);
        check("post_rst_flags", 32'({pe0, fe0}), 32'h0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
